// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one single-port data RAM between the core
// load/store path and a host loader/debug port. One memory op per cycle,
// round-robin with starvation limits, optional host lock, 1-cycle read return
// routed back to the issuing port.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst_n,    // synchronous, active-high despite the name
  // core datapath port
  input  logic              c_re,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_rvalid,
  output logic              c_stall,
  // host loader/debug port
  input  logic              h_req,
  input  logic              h_we,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  // data RAM port
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // Owner of the most recent issue; HOST_LOCK means the host asked to keep it.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CORE      = 2'd1,
    ST_HOST      = 2'd2,
    ST_HOST_LOCK = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_SAT = 4'hF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_c_wait;
  logic [3:0]        r_h_wait;
  logic              r_pend;        // a read issued last cycle; data arrives now
  logic              r_owner_host;  // 1: that read belongs to the host
  logic [DATA_W-1:0] r_c_rdata;     // last data returned to the core
  logic [DATA_W-1:0] r_h_rdata;     // last data returned to the host

  logic              w_rst;
  logic              w_c_req;
  logic              w_c_force;
  logic              w_h_force;
  logic              w_c_gnt;
  logic              w_h_gnt;
  logic              w_c_rvalid;
  logic              w_h_rvalid;

  // rst_n is active-high: 1 holds the block in reset.
  assign w_rst   = rst_n;
  assign w_c_req = c_re | c_we;

  // A requester denied MAX_WAIT cycles in a row must win now.
  assign w_c_force = (r_c_wait >= WAIT_MAX);
  assign w_h_force = (r_h_wait >= WAIT_MAX);

  // State register: remembers who issued last.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (w_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: follow the issuing port; a lock held by an absent host lapses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    if (w_h_gnt) begin
      w_state_nxt = h_lock ? ST_HOST_LOCK : ST_HOST;
    end else if (w_c_gnt) begin
      w_state_nxt = ST_CORE;
    end else if ((r_state == ST_HOST_LOCK) && !h_req) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Grant decision: starvation force, then host lock, then round-robin.
  always_comb begin
    w_c_gnt = 1'b0;
    w_h_gnt = 1'b0;
    if (!w_rst) begin
      if (w_c_req && h_req) begin
        if (w_c_force) begin
          w_c_gnt = 1'b1;          // core wins even when both are starved
        end else if (w_h_force) begin
          w_h_gnt = 1'b1;
        end else if ((r_state == ST_HOST_LOCK) || (r_state == ST_CORE)) begin
          w_h_gnt = 1'b1;
        end else begin
          w_c_gnt = 1'b1;          // IDLE or HOST: core's turn
        end
      end else begin
        w_c_gnt = w_c_req;
        w_h_gnt = h_req;
      end
    end
  end

  // Memory port mux: drive the winner's op; read+write from the core is a write.
  always_comb begin
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_c_gnt) begin
      m_we   = c_we;
      m_re   = c_re & ~c_we;
      m_addr = c_addr;
      if (c_we) begin
        m_wdata = c_wdata;
      end
    end else if (w_h_gnt) begin
      m_we   = h_we;
      m_re   = ~h_we;
      m_addr = h_addr;
      if (h_we) begin
        m_wdata = h_wdata;
      end
    end
  end

  assign c_stall = w_c_req & ~w_c_gnt & ~w_rst;
  assign h_gnt   = w_h_gnt;

  // Starvation counters: count consecutive denied requests, saturating.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_c_wait <= '0;
      r_h_wait <= '0;
    end else begin
      if (w_c_req && !w_c_gnt) begin
        r_c_wait <= (r_c_wait == WAIT_SAT) ? WAIT_SAT : r_c_wait + 4'd1;
      end else begin
        r_c_wait <= '0;
      end
      if (h_req && !w_h_gnt) begin
        r_h_wait <= (r_h_wait == WAIT_SAT) ? WAIT_SAT : r_h_wait + 4'd1;
      end else begin
        r_h_wait <= '0;
      end
    end
  end

  // Read tracking: remember that a read went out and which port issued it.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_pend       <= 1'b0;
      r_owner_host <= 1'b0;
    end else begin
      r_pend       <= m_re;
      r_owner_host <= w_h_gnt;
    end
  end

  assign w_c_rvalid = r_pend & ~r_owner_host & ~w_rst;
  assign w_h_rvalid = r_pend &  r_owner_host & ~w_rst;

  // Returned data holders: keep the last word delivered to each port.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_c_rdata <= '0;
      r_h_rdata <= '0;
    end else begin
      if (w_c_rvalid) begin
        r_c_rdata <= m_rdata;
      end
      if (w_h_rvalid) begin
        r_h_rdata <= m_rdata;
      end
    end
  end

  // Fresh RAM data passes straight through on the return cycle.
  assign c_rvalid = w_c_rvalid;
  assign h_rvalid = w_h_rvalid;
  assign c_rdata  = w_rst ? '0 : (w_c_rvalid ? m_rdata : r_c_rdata);
  assign h_rdata  = w_rst ? '0 : (w_h_rvalid ? m_rdata : r_h_rdata);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic, all
// compared each cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_re, c_we, h_req, h_we, h_lock;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wdata, h_wdata;
  logic [DW-1:0] c_rdata, h_rdata;
  logic          c_rvalid, c_stall, h_gnt, h_rvalid;
  logic          m_re, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_re(c_re), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_stall(c_stall),
    .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Data RAM: write at the edge, read data one cycle after m_re.
  logic [DW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (m_we) tb_mem[m_addr] <= m_wdata;
    if (m_re) m_rdata <= tb_mem[m_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: last issuer (0 none, 1 core, 2 host), lock flag, wait
  // counts, its own copy of RAM, and at most one read in flight.
  logic [DW-1:0] mdl_ram [256];
  int            mdl_last = 0;
  bit            mdl_locked = 0;
  int            mdl_cw = 0;
  int            mdl_hw = 0;
  bit            mdl_pend = 0;
  int            mdl_powner = 0;
  logic [DW-1:0] mdl_pdata = '0;
  logic [DW-1:0] mdl_chold = '0;
  logic [DW-1:0] mdl_hhold = '0;

  // Expectations for the cycle currently applied.
  int            e_win;
  bit            e_mre, e_mwe, e_crv, e_hrv;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwd;
  logic [45:0]   e_ctl;
  logic [63:0]   e_dat;

  function automatic logic [45:0] obs_ctl();
    return {c_stall, h_gnt, m_re, m_we, m_addr, m_wdata, c_rvalid, h_rvalid};
  endfunction

  // Drive one cycle of inputs, derive expectations, move to the sample point.
  task automatic apply(input bit rst, input bit cre, input bit cwe,
                       input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit hreq, input bit hwe, input bit hlk,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    bit creq;
    rst_n = rst; c_re = cre; c_we = cwe; c_addr = ca; c_wdata = cd;
    h_req = hreq; h_we = hwe; h_lock = hlk; h_addr = ha; h_wdata = hd;
    creq  = cre | cwe;
    e_win = 0;
    if (!rst) begin
      if (creq && hreq) begin
        if (mdl_cw >= MW)                      e_win = 1;
        else if (mdl_hw >= MW)                 e_win = 2;
        else if (mdl_locked || mdl_last == 1)  e_win = 2;
        else                                   e_win = 1;
      end else if (creq) e_win = 1;
      else if (hreq)     e_win = 2;
    end
    e_mwe   = (e_win == 1 && cwe) || (e_win == 2 && hwe);
    e_mre   = (e_win == 1 && cre && !cwe) || (e_win == 2 && !hwe);
    e_maddr = (e_win == 1) ? ca : (e_win == 2) ? ha : '0;
    e_mwd   = !e_mwe ? '0 : (e_win == 1) ? cd : hd;
    e_crv   = !rst && mdl_pend && mdl_powner == 1;
    e_hrv   = !rst && mdl_pend && mdl_powner == 2;
    e_ctl   = {(!rst && creq && e_win != 1), (e_win == 2), e_mre, e_mwe,
               e_maddr, e_mwd, e_crv, e_hrv};
    e_dat   = {(rst ? 32'h0 : (e_crv ? mdl_pdata : mdl_chold)),
               (rst ? 32'h0 : (e_hrv ? mdl_pdata : mdl_hhold))};
    @(negedge clk);
  endtask

  // Take the clock edge and advance the reference model to match.
  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      mdl_last = 0; mdl_locked = 0; mdl_cw = 0; mdl_hw = 0;
      mdl_pend = 0; mdl_chold = '0; mdl_hhold = '0;
    end else begin
      if (mdl_pend) begin
        if (mdl_powner == 1) mdl_chold = mdl_pdata;
        else                 mdl_hhold = mdl_pdata;
      end
      mdl_pend   = e_mre;
      mdl_powner = e_win;
      if (e_mre) mdl_pdata = mdl_ram[e_maddr];
      if (e_mwe) mdl_ram[e_maddr] = e_mwd;
      mdl_cw = ((c_re | c_we) && e_win != 1) ? ((mdl_cw < 15) ? mdl_cw + 1 : 15) : 0;
      mdl_hw = (h_req && e_win != 2) ? ((mdl_hw < 15) ? mdl_hw + 1 : 15) : 0;
      if (e_win == 2) begin
        mdl_last = 2; mdl_locked = h_lock;
      end else if (e_win == 1) begin
        mdl_last = 1; mdl_locked = 0;
      end else if (mdl_locked && !h_req) begin
        mdl_last = 0; mdl_locked = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      apply(1, 1, 0, 8'h10, 32'h0, 1, 1, 1, 8'h20, 32'h1234);
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL reset_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ({h_gnt, m_re, m_we, c_stall, c_rvalid, h_rvalid, c_rdata, h_rdata} !== 70'h0) begin
        errors++; $display("FAIL reset_zero step %0d got gnt=%b re=%b we=%b stall=%b crd=%h hrd=%h",
                           s, h_gnt, m_re, m_we, c_stall, c_rdata, h_rdata);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_contention();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: apply(0, 0, 1, 8'h30, 32'hCAFE0030, 1, 0, 0, 8'h20, 32'h0);
        1: apply(0, 1, 0, 8'h40, 32'h0, 1, 0, 0, 8'h20, 32'h0);
        2: apply(0, 1, 0, 8'h40, 32'h0, 0, 0, 0, 8'h00, 32'h0);
        default: apply(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      endcase
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL contention_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ({c_rdata, h_rdata} !== e_dat) begin
        errors++; $display("FAIL contention_data step %0d got %h exp %h", s, {c_rdata, h_rdata}, e_dat);
      end
      checks++;
      if (s == 0 && {m_we, c_stall, h_gnt} !== 3'b100) begin
        errors++; $display("FAIL contention_first got we/stall/gnt=%b exp 100", {m_we, c_stall, h_gnt});
      end
      if (s == 1 && {h_gnt, c_stall} !== 2'b11) begin
        errors++; $display("FAIL contention_second got gnt/stall=%b exp 11", {h_gnt, c_stall});
      end
      if (s == 2 && {h_rvalid, h_rdata} !== {1'b1, 32'h10002020}) begin
        errors++; $display("FAIL contention_hread got v=%b d=%h exp 1 10002020", h_rvalid, h_rdata);
      end
      if (s < 3) checks++;
      advance();
    end
  endtask

  task automatic test_core_only();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) apply(0, 1, 0, 8'h10, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      else        apply(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL core_only_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if (s == 0 && {m_re, c_stall} !== 2'b10) begin
        errors++; $display("FAIL core_only_issue got re/stall=%b exp 10", {m_re, c_stall});
      end
      if (s == 1 && {c_rvalid, h_rvalid, c_rdata} !== {2'b10, 32'hDEADBEEF}) begin
        errors++; $display("FAIL core_only_return got cv=%b hv=%b d=%h exp 1 0 deadbeef",
                           c_rvalid, h_rvalid, c_rdata);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_host_lock();
    int hidx = 0;
    for (int s = 0; s < 15; s++) begin
      apply(0, (s >= 1 && s <= 12), 0, 8'h50, 32'h0,
            (hidx < 8), 1, 1, 8'(hidx), 32'hB0000000 + 32'(hidx));
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL host_lock_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ({c_rdata, h_rdata} !== e_dat) begin
        errors++; $display("FAIL host_lock_data step %0d got %h exp %h", s, {c_rdata, h_rdata}, e_dat);
      end
      checks++;
      if ((s == 4 && c_stall !== 1'b1) || (s == 5 && c_stall !== 1'b0)) begin
        errors++; $display("FAIL host_lock_force step %0d got stall=%b", s, c_stall);
      end
      if (s == 4 || s == 5) checks++;
      if (e_win == 2) hidx++;
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      if (tb_mem[i] !== 32'hB0000000 + 32'(i)) begin
        errors++; $display("FAIL host_lock_ram addr %0d got %h exp %h", i, tb_mem[i], 32'hB0000000 + 32'(i));
      end
      checks++;
    end
  endtask

  task automatic test_alternating();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: apply(0, 1, 0, 8'h01, 32'h0, 0, 0, 0, 8'h00, 32'h0);
        1: apply(0, 0, 0, 8'h00, 32'h0, 1, 0, 0, 8'h02, 32'h0);
        2: apply(0, 1, 0, 8'h03, 32'h0, 0, 0, 0, 8'h00, 32'h0);
        default: apply(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      endcase
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL alternating_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ((s == 1 && {c_rvalid, h_rvalid, c_rdata} !== {2'b10, 32'hB0000001}) ||
          (s == 2 && {c_rvalid, h_rvalid, h_rdata} !== {2'b01, 32'hB0000002}) ||
          (s == 3 && {c_rvalid, h_rvalid, c_rdata} !== {2'b10, 32'hB0000003}) ||
          (s == 4 && {c_rvalid, h_rvalid} !== 2'b00)) begin
        errors++; $display("FAIL alternating_return step %0d got cv=%b hv=%b crd=%h hrd=%h",
                           s, c_rvalid, h_rvalid, c_rdata, h_rdata);
      end
      if (s >= 1) checks++;
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: apply(0, 1, 0, 8'h10, 32'h0, 0, 0, 0, 8'h00, 32'h0);
        1, 2: apply(1, 1, 0, 8'h11, 32'h0, 1, 0, 0, 8'h12, 32'h0);
        3: apply(0, 1, 0, 8'h11, 32'h0, 1, 0, 0, 8'h12, 32'h0);
        default: apply(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      endcase
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL reset_mid_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ((s == 1 || s == 2) && {c_rvalid, c_rdata, m_re, h_gnt} !== 35'h0) begin
        errors++; $display("FAIL reset_mid_drop step %0d got cv=%b crd=%h", s, c_rvalid, c_rdata);
      end
      if (s == 3 && {h_gnt, c_stall, m_re, m_addr} !== {3'b001, 8'h11}) begin
        errors++; $display("FAIL reset_mid_first got gnt=%b stall=%b re=%b addr=%h exp core read 11",
                           h_gnt, c_stall, m_re, m_addr);
      end
      if (s >= 1 && s <= 3) checks++;
      advance();
    end
  endtask

  task automatic test_rw_both();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: apply(0, 1, 1, 8'h60, 32'h600D600D, 0, 0, 0, 8'h00, 32'h0);
        2: apply(0, 1, 0, 8'h60, 32'h0, 0, 0, 0, 8'h00, 32'h0);
        default: apply(0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 8'h00, 32'h0);
      endcase
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL rw_both_ctl step %0d got %h exp %h", s, obs_ctl(), e_ctl);
      end
      checks++;
      if ((s == 0 && {m_we, m_re} !== 2'b10) || (s == 1 && c_rvalid !== 1'b0) ||
          (s == 3 && {c_rvalid, c_rdata} !== {1'b1, 32'h600D600D})) begin
        errors++; $display("FAIL rw_both_spot step %0d got we=%b re=%b cv=%b crd=%h",
                           s, m_we, m_re, c_rvalid, c_rdata);
      end
      if (s != 2) checks++;
      advance();
    end
  endtask

  task automatic test_random();
    bit c_hold = 0, h_hold = 0;
    bit cre = 0, cwe = 0, hreq = 0, hwe = 0, hlk = 0, rst;
    logic [AW-1:0] ca = '0, ha = '0;
    logic [DW-1:0] cd = '0, hd = '0;
    int k;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!c_hold) begin
        k   = $urandom_range(0, 4);
        cre = (k == 1 || k == 3);
        cwe = (k == 2 || k == 3);
        ca  = 8'($urandom_range(0, 15));
        cd  = $urandom;
      end
      if (!h_hold) begin
        hreq = 1'($urandom_range(0, 1));
        hwe  = 1'($urandom_range(0, 1));
        hlk  = ($urandom_range(0, 2) != 0);
        ha   = 8'($urandom_range(0, 15));
        hd   = $urandom;
      end
      apply(rst, cre, cwe, ca, cd, hreq, hwe, hlk, ha, hd);
      if (obs_ctl() !== e_ctl) begin
        errors++; $display("FAIL random_ctl cyc %0d got %h exp %h", cyc, obs_ctl(), e_ctl);
      end
      checks++;
      if ({c_rdata, h_rdata} !== e_dat) begin
        errors++; $display("FAIL random_data cyc %0d got %h exp %h", cyc, {c_rdata, h_rdata}, e_dat);
      end
      checks++;
      c_hold = (cre | cwe) && e_win != 1 && !rst;
      h_hold = hreq && e_win != 2 && !rst;
      advance();
    end
    for (int i = 0; i < 16; i++) begin
      if (tb_mem[i] !== mdl_ram[i]) begin
        errors++; $display("FAIL random_ram addr %0d got %h exp %h", i, tb_mem[i], mdl_ram[i]);
      end
      checks++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'h10000000 + 32'(i) * 32'h0101;
      mdl_ram[i] = 32'h10000000 + 32'(i) * 32'h0101;
    end
    tb_mem[8'h10]  = 32'hDEADBEEF;
    mdl_ram[8'h10] = 32'hDEADBEEF;
    rst_n = 1; c_re = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_lock = 0; h_addr = '0; h_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_core_only();
    test_host_lock();
    test_alternating();
    test_reset_mid_read();
    test_rw_both();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
